// File: rtl/gate_sweep_ctrl.sv
// Purpose : drives a 2-input gate through {A,B}=00,10,01,11 and checks each sampled X against TRUTH.
// Latency : DONE rises 4*(SETTLE+1) cycles after the edge that accepts START (12 at SETTLE=2).
// Backpressure: none; START is only looked at in IDLE, so a request made while busy is dropped, not queued.
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   start           - run request, sampled only in IDLE
//   x               - combinational output of the gate under control
//   a, b            - registered gate inputs
//   busy            - high from the cycle after START is accepted through the last sample cycle
//   done            - one-cycle pulse when the sweep completes
//   pass            - last sweep had zero mismatches; held until the next accepted START
//   result          - captured X per vector index {B,A}; held until the next accepted START
//   err_cnt         - mismatch count of the last or current sweep (0..4)
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  TRUTH  = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       x,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result,
    output logic [2:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    // DRIVE lasts SETTLE cycles; the counter is compared against its last value.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_d, b_d, busy_d, done_d, pass_d;
    logic [3:0] result_d;
    logic [2:0] err_d;
    logic [1:0] idx_inc;
    logic       mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            result  <= 4'd0;
            err_cnt <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a       <= a_d;
            b       <= b_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
            result  <= result_d;
            err_cnt <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        a_d      = a;
        b_d      = b;
        busy_d   = busy;
        done_d   = 1'b0;
        pass_d   = pass;
        result_d = result;
        err_d    = err_cnt;
        idx_inc  = 2'(idx_q + 2'd1);
        mismatch = (x != TRUTH[idx_q]);

        case (state_q)
            IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (start) begin
                    state_d  = DRIVE;
                    idx_d    = 2'd0;
                    cnt_d    = 4'd0;
                    result_d = 4'd0;
                    err_d    = 3'd0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            DRIVE: begin
                cnt_d = 4'(cnt_q + 4'd1);
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                result_d[idx_q] = x;
                if (mismatch) begin
                    err_d = 3'(err_cnt + 3'd1);
                end
                if (idx_q != 2'd3) begin
                    idx_d   = idx_inc;
                    a_d     = idx_inc[0];
                    b_d     = idx_inc[1];
                    cnt_d   = 4'd0;
                    state_d = DRIVE;
                end else begin
                    // PASS is settled here so it already includes the vector-3 verdict when DONE rises.
                    state_d = FINISH;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 3'd0);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Purpose : directed bench for gate_sweep_ctrl with a default (SETTLE=2) and a SETTLE=1 instance.
// Latency : expected timings are counted in clock edges from the edge that accepts START.
// Backpressure: not applicable; START pulses during a sweep are checked to be ignored.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [1:0] mode = 2'd0;   // 0: NAND, 1: AND, 2: stuck-at-1
    logic       x0, x1;
    logic       a0, b0, busy0, done0, pass0;
    logic [3:0] result0;
    logic [2:0] err0;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] result1;
    logic [2:0] err1;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            2'd1:    x0 = a0 & b0;
            2'd2:    x0 = 1'b1;
            default: x0 = ~(a0 & b0);
        endcase
    end
    assign x1 = ~(a1 & b1);

    gate_sweep_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .x(x0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .result(result0), .err_cnt(err0)
    );

    gate_sweep_ctrl #(.SETTLE(1), .TRUTH(4'b0111)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x(x1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .result(result1), .err_cnt(err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on the default instance; k counts edges after the accepting edge.
    task automatic sweep0(input string tag, input logic [3:0] exp_res,
                          input logic [2:0] exp_err, input logic exp_pass);
        logic [1:0] v;
        @(negedge clk);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) step();
            chk({tag, "_busy"}, 32'(busy0), 32'(k <= 11));
            chk({tag, "_done"}, 32'(done0), 32'(k == 12));
            if (k <= 11) begin
                v = 2'(k / 3);
                chk({tag, "_ab"}, 32'({a0, b0}), 32'({v[0], v[1]}));
            end else begin
                chk({tag, "_ab_idle"}, 32'({a0, b0}), 32'd0);
            end
            if (k >= 12) begin
                chk({tag, "_result"}, 32'(result0), 32'(exp_res));
                chk({tag, "_err"}, 32'(err0), 32'(exp_err));
                chk({tag, "_pass"}, 32'(pass0), 32'(exp_pass));
            end
        end
    endtask

    initial begin
        // 1. asynchronous reset, then 20 idle cycles
        #12;
        rst_n = 1'b0;
        #1;
        chk("rst_outs0", 32'({a0, b0, busy0, done0, pass0, result0, err0}), 32'd0);
        chk("rst_outs1", 32'({a1, b1, busy1, done1, pass1, result1, err1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_outs", 32'({a0, b0, busy0, done0, pass0, result0, err0}), 32'd0);
        end

        // 2-4. default instance against NAND, AND and stuck-at-1
        mode = 2'd0;
        sweep0("nand", 4'b0111, 3'd0, 1'b1);
        mode = 2'd1;
        sweep0("and", 4'b1000, 3'd4, 1'b0);
        mode = 2'd2;
        sweep0("stuck1", 4'b1111, 3'd1, 1'b0);
        mode = 2'd0;

        // 5. SETTLE=1: pulses at edges 3 and 5 are ignored, DONE at edge 8
        @(negedge clk);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            start1 = (k == 2 || k == 4);
            chk("s1_done", 32'(done1), 32'(k == 8));
            chk("s1_busy", 32'(busy1), 32'(k <= 7));
        end
        chk("s1_result", 32'(result1), 32'h7);
        chk("s1_pass", 32'(pass1), 32'd1);
        // hold START: FINISH ignores it, one IDLE cycle, then re-accepted
        start1 = 1'b1;
        step();
        chk("s1_idle_busy", 32'(busy1), 32'd0);
        chk("s1_idle_result", 32'(result1), 32'h7);
        step();
        chk("s1_reacc_busy", 32'(busy1), 32'd1);
        chk("s1_reacc_clear", 32'({pass1, result1, err1}), 32'd0);
        start1 = 1'b0;
        for (int k = 11; k <= 18; k++) begin
            step();
            chk("s1_2nd_done", 32'(done1), 32'(k == 18));
        end
        chk("s1_2nd_pass", 32'(pass1), 32'd1);

        // 6. reset while idx=2 in DRIVE, then a clean rerun
        @(negedge clk);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        chk("mid_ab", 32'({a0, b0}), 32'b01);
        chk("mid_partial", 32'(result0), 32'b0011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({a0, b0, busy0, done0, pass0, result0, err0}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_rst_nodone", 32'(done0), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'({busy0, done0, result0}), 32'd0);
        sweep0("rerun", 4'b0111, 3'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
